input_conditioner: RTL and testbench

Input-side counterpart of the LED/7-seg output path. It conditions the raw board slide switches SW[8:0] and push-button KEY0 before the top level uses them. Each input is synchronized to CLOCK_50 and debounced independently. The block presents stable switch fields (mode, state, divider select), a debounced key level, and one-cycle event pulses for the mode engines and reset logic.

---
 rtl/input_conditioner.sv | 91 +++++++++
 tb/tb_input_conditioner.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Synchronizes and debounces the board slide switches and KEY0, then exposes
// stable switch fields, a debounced key level and one-cycle change events.
module input_conditioner #(
  parameter int SW_WIDTH        = 9,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [SW_WIDTH-1:0] SW_raw,
  input  logic                KEY_raw,
  output logic [SW_WIDTH-1:0] SW_stable,
  output logic [1:0]          mode_sel,
  output logic [2:0]          state_sel,
  output logic [3:0]          hz_sel,
  output logic                key_pressed,
  output logic                key_press_pulse,
  output logic                key_release_pulse,
  output logic                sw_change_pulse,
  output logic                mode_change_pulse
);

  localparam int CH = SW_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0] sw_meta, sw_sync;
  logic                key_meta, key_sync;

  logic [CH-1:0]                sync_all;
  logic [CH-1:0]                stable_q, stable_next;
  logic [CH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_next;

  // Key flops park at 1 so a released button is the reset condition.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      sw_meta  <= SW_raw;
      sw_sync  <= sw_meta;
      key_meta <= KEY_raw;
      key_sync <= key_meta;
    end
  end

  // Top channel carries the key inverted so every channel is active-high.
  assign sync_all = {~key_sync, sw_sync};

  always_comb begin
    stable_next = stable_q;
    cnt_next    = '0;
    for (int ch = 0; ch < CH; ch++) begin
      if (sync_all[ch] != stable_q[ch]) begin
        if (cnt_q[ch] == CNT_LAST) begin
          stable_next[ch] = sync_all[ch];
        end else begin
          cnt_next[ch] = cnt_q[ch] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Pulses are derived from the same edge that commits the new stable value,
  // so they line up with the first cycle the new level is visible.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      stable_q          <= '0;
      cnt_q             <= '0;
      key_press_pulse   <= 1'b0;
      key_release_pulse <= 1'b0;
      sw_change_pulse   <= 1'b0;
      mode_change_pulse <= 1'b0;
    end else begin
      stable_q          <= stable_next;
      cnt_q             <= cnt_next;
      key_press_pulse   <= stable_next[SW_WIDTH] & ~stable_q[SW_WIDTH];
      key_release_pulse <= ~stable_next[SW_WIDTH] & stable_q[SW_WIDTH];
      sw_change_pulse   <= |(stable_next[SW_WIDTH-1:0] ^ stable_q[SW_WIDTH-1:0]);
      mode_change_pulse <= |(stable_next[1:0] ^ stable_q[1:0]);
    end
  end

  assign SW_stable   = stable_q[SW_WIDTH-1:0];
  assign key_pressed = stable_q[SW_WIDTH];
  assign mode_sel    = SW_stable[1:0];
  assign state_sel   = SW_stable[4:2];
  assign hz_sel      = SW_stable[8:5];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed and randomized bench for input_conditioner with a short debounce
// window, checked against a sliding-window reference model.
module tb_input_conditioner;

  localparam int SW_WIDTH = 9;
  localparam int D        = 4;
  localparam int CH       = SW_WIDTH + 1;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [SW_WIDTH-1:0] sw_raw;
  logic                key_raw;
  logic [SW_WIDTH-1:0] sw_stable;
  logic [1:0]          mode_sel;
  logic [2:0]          state_sel;
  logic [3:0]          hz_sel;
  logic                key_pressed, key_press_pulse, key_release_pulse;
  logic                sw_change_pulse, mode_change_pulse;

  always #5 clk = ~clk;

  input_conditioner #(
    .SW_WIDTH(SW_WIDTH), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(20)
  ) dut (
    .CLOCK_50(clk), .RESET_N(reset_n), .SW_raw(sw_raw), .KEY_raw(key_raw),
    .SW_stable(sw_stable), .mode_sel(mode_sel), .state_sel(state_sel), .hz_sel(hz_sel),
    .key_pressed(key_pressed), .key_press_pulse(key_press_pulse),
    .key_release_pulse(key_release_pulse), .sw_change_pulse(sw_change_pulse),
    .mode_change_pulse(mode_change_pulse)
  );

  int checks = 0;
  int errors = 0;

  // Model: a channel flips once its last D synchronized samples all disagree
  // with the current stable level; samples reach the debouncer two edges late.
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_stable;
  logic          m_press, m_release, m_sw_chg, m_mode_chg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_stable   = '0;
    m_press    = 1'b0;
    m_release  = 1'b0;
    m_sw_chg   = 1'b0;
    m_mode_chg = 1'b0;
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_front('0);
  endfunction

  function automatic void model_edge();
    logic [CH-1:0] nxt;
    logic          all_differ;
    if (!reset_n) return;
    nxt = m_stable;
    for (int ch = 0; ch < CH; ch++) begin
      all_differ = 1'b1;
      for (int i = 1; i <= D; i++)
        if (hist[i][ch] == m_stable[ch]) all_differ = 1'b0;
      if (all_differ) nxt[ch] = ~m_stable[ch];
    end
    m_press    = nxt[SW_WIDTH] && !m_stable[SW_WIDTH];
    m_release  = !nxt[SW_WIDTH] && m_stable[SW_WIDTH];
    m_sw_chg   = nxt[SW_WIDTH-1:0] != m_stable[SW_WIDTH-1:0];
    m_mode_chg = nxt[1:0] != m_stable[1:0];
    m_stable   = nxt;
    hist.push_front({~key_raw, sw_raw});
    void'(hist.pop_back());
  endfunction

  task automatic check_output();
    check("sw_stable", 32'(sw_stable), 32'(m_stable[SW_WIDTH-1:0]));
    check("mode_sel", 32'(mode_sel), 32'(m_stable[1:0]));
    check("state_sel", 32'(state_sel), 32'(m_stable[4:2]));
    check("hz_sel", 32'(hz_sel), 32'(m_stable[8:5]));
    check("key_pressed", 32'(key_pressed), 32'(m_stable[SW_WIDTH]));
    check("key_press_pulse", 32'(key_press_pulse), 32'(m_press));
    check("key_release_pulse", 32'(key_release_pulse), 32'(m_release));
    check("sw_change_pulse", 32'(sw_change_pulse), 32'(m_sw_chg));
    check("mode_change_pulse", 32'(mode_change_pulse), 32'(m_mode_chg));
  endtask

  // Drive at the falling edge, advance the model on the rising edge, check
  // on the next falling edge.
  task automatic apply_stimulus(input logic [SW_WIDTH-1:0] sw, input logic key);
    sw_raw  = sw;
    key_raw = key;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_output();
  endtask

  task automatic enter_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_output();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [SW_WIDTH-1:0] cur_sw;
    logic                cur_key;
    int                  sw_pulses, mode_pulses, any_pulses;

    sw_raw  = 9'h1FF;
    key_raw = 1'b1;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset with all switches up, then release.
    enter_reset();
    check("t1_rst_sw", 32'(sw_stable), 32'h0);
    for (int i = 0; i < 3; i++) apply_stimulus(9'h1FF, 1'b1);
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      apply_stimulus(9'h1FF, 1'b1);
      check("t1_sw", 32'(sw_stable), (e >= 6) ? 32'h1FF : 32'h0);
      check("t1_hz", 32'(hz_sel), (e >= 6) ? 32'd15 : 32'd0);
      check("t1_swp", 32'(sw_change_pulse), 32'(e == 6));
      check("t1_mdp", 32'(mode_change_pulse), 32'(e == 6));
    end

    // Key press held, then released.
    for (int e = 1; e <= 20; e++) begin
      apply_stimulus(9'h1FF, 1'b0);
      check("t2_kp", 32'(key_pressed), 32'(e >= 6));
      check("t2_kpp", 32'(key_press_pulse), 32'(e == 6));
    end
    for (int e = 1; e <= 20; e++) begin
      apply_stimulus(9'h1FF, 1'b1);
      check("t2_kr", 32'(key_pressed), 32'(e < 6));
      check("t2_krp", 32'(key_release_pulse), 32'(e == 6));
    end

    // Bouncing SW[0] from a settled low level.
    for (int i = 0; i < 10; i++) apply_stimulus(9'h1FE, 1'b1);
    sw_pulses = 0;
    for (int i = 0; i < 30; i++) begin
      apply_stimulus(((i / 3) % 2 == 0) ? 9'h1FF : 9'h1FE, 1'b1);
      sw_pulses += int'(sw_change_pulse);
      check("t3_bounce", 32'(sw_stable[0]), 32'h0);
    end
    check("t3_no_pulse", 32'(sw_pulses), 32'd0);
    mode_pulses = 0;
    for (int e = 1; e <= 10; e++) begin
      apply_stimulus(9'h1FF, 1'b1);
      sw_pulses   += int'(sw_change_pulse);
      mode_pulses += int'(mode_change_pulse);
      check("t3_rise", 32'(sw_stable[0]), 32'(e >= 6));
    end
    check("t3_swp_cnt", 32'(sw_pulses), 32'd1);
    check("t3_mdp_cnt", 32'(mode_pulses), 32'd1);

    // Short glitches on SW[7] and KEY.
    any_pulses = 0;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus((i < 3) ? 9'h17F : 9'h1FF, (i < 2) ? 1'b0 : 1'b1);
      any_pulses += int'(sw_change_pulse) + int'(mode_change_pulse)
                  + int'(key_press_pulse) + int'(key_release_pulse);
      check("t4_sw", 32'(sw_stable), 32'h1FF);
      check("t4_key", 32'(key_pressed), 32'h0);
    end
    check("t4_pulses", 32'(any_pulses), 32'd0);

    // state and hz fields change together while mode holds.
    for (int e = 1; e <= 10; e++) begin
      apply_stimulus(9'h003, 1'b1);
      check("t5_state", 32'(state_sel), (e >= 6) ? 32'd0 : 32'd7);
      check("t5_hz", 32'(hz_sel), (e >= 6) ? 32'd0 : 32'd15);
      check("t5_swp", 32'(sw_change_pulse), 32'(e == 6));
      check("t5_mdp", 32'(mode_change_pulse), 32'h0);
    end

    // Reset in the middle of debouncing SW[1].
    for (int i = 0; i < 10; i++) apply_stimulus(9'h001, 1'b1);
    for (int i = 0; i < 4; i++) apply_stimulus(9'h003, 1'b1);
    enter_reset();
    check("t6_rst_sw", 32'(sw_stable), 32'h0);
    check("t6_rst_p", 32'(sw_change_pulse), 32'h0);
    apply_stimulus(9'h003, 1'b1);
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      apply_stimulus(9'h003, 1'b1);
      check("t6_sw1", 32'(sw_stable[1]), 32'(e >= 6));
      check("t6_mdp", 32'(mode_change_pulse), 32'(e == 6));
    end

    // Randomized traffic with one reset in the middle.
    cur_sw  = 9'h003;
    cur_key = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) cur_sw[$urandom_range(0, SW_WIDTH - 1)] ^= 1'b1;
      if ($urandom_range(0, 6) == 0) cur_sw = SW_WIDTH'($urandom);
      if ($urandom_range(0, 4) == 0) cur_key = ~cur_key;
      if (i == 300) begin
        enter_reset();
        apply_stimulus(cur_sw, cur_key);
        reset_n = 1'b1;
      end
      apply_stimulus(cur_sw, cur_key);
      if ($urandom_range(0, 2) == 0)
        for (int h = 0; h < int'($urandom_range(1, 7)); h++) apply_stimulus(cur_sw, cur_key);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
